// File: rtl/regfile_sb_if.sv
// Register file bus: WB write port, three operand read ports,
// decode issue marking and the resulting stall/error status.
interface regfile_sb_if #(
    parameter int FULLW = 32,
    parameter int REGAW = 4
);
    logic             we_in;
    logic [REGAW-1:0] wa_in;
    logic [FULLW-1:0] wd_in;
    logic [REGAW-1:0] ra1_in;
    logic [REGAW-1:0] ra2_in;
    logic [REGAW-1:0] ra3_in;
    logic             re1_in;
    logic             re2_in;
    logic             re3_in;
    logic [FULLW-1:0] rd1_out;
    logic [FULLW-1:0] rd2_out;
    logic [FULLW-1:0] rd3_out;
    logic [FULLW-1:0] pc_in;
    logic             issue_valid_in;
    logic             issue_we_in;
    logic [REGAW-1:0] issue_wa_in;
    logic             stall_out;
    logic             sb_err_out;

    modport master (
        output we_in, wa_in, wd_in,
        output ra1_in, ra2_in, ra3_in,
        output re1_in, re2_in, re3_in,
        output pc_in,
        output issue_valid_in, issue_we_in, issue_wa_in,
        input  rd1_out, rd2_out, rd3_out,
        input  stall_out, sb_err_out
    );

    modport slave (
        input  we_in, wa_in, wd_in,
        input  ra1_in, ra2_in, ra3_in,
        input  re1_in, re2_in, re3_in,
        input  pc_in,
        input  issue_valid_in, issue_we_in, issue_wa_in,
        output rd1_out, rd2_out, rd3_out,
        output stall_out, sb_err_out
    );
endinterface

// File: rtl/regfile_sb.sv
// Architectural register file with WB bypass, PC+8 view of r15
// and a per-register pending-write scoreboard driving RAW stalls.
module regfile_sb #(
    parameter int FULLW = 32,
    parameter int REGAW = 4,
    parameter int NREGS = 16,
    parameter int PC_i  = 15,
    parameter int CNTW  = 2
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam logic [REGAW-1:0] PC_A    = REGAW'(PC_i);
    localparam logic [CNTW-1:0]  CNT_MAX = '1;
    localparam logic [CNTW-1:0]  CNT_ONE = CNTW'(1);

    logic [FULLW-1:0] regs [NREGS];
    logic [CNTW-1:0]  cnt  [NREGS];
    logic             sb_err;

    logic [REGAW-1:0] ra [3];
    logic [2:0]       re;
    logic [FULLW-1:0] rd [3];
    logic [2:0]       port_stall;

    logic             ret;
    logic             sat;
    logic             stall;
    logic             accept;
    logic             underflow;
    logic [FULLW-1:0] pc8;
    logic [NREGS-1:0] inc_v;
    logic [NREGS-1:0] dec_v;

    assign ra[0] = bus.ra1_in;
    assign ra[1] = bus.ra2_in;
    assign ra[2] = bus.ra3_in;
    assign re    = {bus.re3_in, bus.re2_in, bus.re1_in};

    assign pc8 = bus.pc_in + FULLW'(8);
    assign ret = bus.we_in && (bus.wa_in != PC_A);

    // Operand read with PC view, WB bypass and per-port RAW check
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd[p] = regs[ra[p]];
            port_stall[p] = 1'b0;
            if (ra[p] == PC_A) begin
                rd[p] = pc8;
            end else begin
                if (ret && (bus.wa_in == ra[p]))
                    rd[p] = bus.wd_in;
                port_stall[p] = re[p] && (cnt[ra[p]] != '0) &&
                    !(bus.we_in && (bus.wa_in == ra[p]) &&
                      (cnt[ra[p]] == CNT_ONE));
            end
        end
    end

    assign sat = bus.issue_valid_in && bus.issue_we_in &&
                 (bus.issue_wa_in != PC_A) &&
                 (cnt[bus.issue_wa_in] == CNT_MAX);

    assign stall  = (|port_stall) || sat;
    assign accept = bus.issue_valid_in && bus.issue_we_in && !stall &&
                    (bus.issue_wa_in != PC_A);
    assign underflow = ret && (cnt[bus.wa_in] == '0);

    // Decode which counters are marked by issue and cleared by WB
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int i = 0; i < NREGS; i++) begin
            inc_v[i] = accept && (bus.issue_wa_in == REGAW'(i));
            dec_v[i] = ret && (bus.wa_in == REGAW'(i));
        end
    end

    // Register data: WB writes land at the edge, r15 writes dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (ret) begin
            regs[bus.wa_in] <= bus.wd_in;
        end
    end

    // Pending counters: issue marks, WB clears, same-reg pair cancels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (inc_v[i] && !dec_v[i])
                    cnt[i] <= cnt[i] + CNT_ONE;
                else if (dec_v[i] && !inc_v[i] && cnt[i] != '0)
                    cnt[i] <= cnt[i] - CNT_ONE;
            end
        end
    end

    // Sticky flag for a WB retire with nothing pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sb_err <= 1'b0;
        else if (underflow)
            sb_err <= 1'b1;
    end

    assign bus.rd1_out    = rd[0];
    assign bus.rd2_out    = rd[1];
    assign bus.rd3_out    = rd[2];
    assign bus.stall_out  = stall;
    assign bus.sb_err_out = sb_err;
endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb against a behavioural model,
// with directed literal checks that pin the model.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_sb_if #(.FULLW(32), .REGAW(4)) bus ();

    regfile_sb dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_reg [16];
    int          m_cnt [16];
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        if (a == 4'd15) return bus.pc_in + 32'd8;
        if (bus.we_in && bus.wa_in == a) return bus.wd_in;
        return m_reg[a];
    endfunction

    function automatic logic src_blocked(input logic en, input logic [3:0] a);
        if (!en || a == 4'd15 || m_cnt[a] == 0) return 1'b0;
        if (bus.we_in && bus.wa_in == a && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_stall();
        logic s;
        s = src_blocked(bus.re1_in, bus.ra1_in) ||
            src_blocked(bus.re2_in, bus.ra2_in) ||
            src_blocked(bus.re3_in, bus.ra3_in);
        if (bus.issue_valid_in && bus.issue_we_in &&
            bus.issue_wa_in != 4'd15 && m_cnt[bus.issue_wa_in] == 3)
            s = 1'b1;
        return s;
    endfunction

    // Model state: count of outstanding writes per register
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_reg[i] <= '0;
                m_cnt[i] <= 0;
            end
            m_err <= 1'b0;
        end else begin
            logic ret, acc;
            ret = bus.we_in && bus.wa_in != 4'd15;
            acc = bus.issue_valid_in && bus.issue_we_in &&
                  bus.issue_wa_in != 4'd15 && !exp_stall();
            if (ret) begin
                m_reg[bus.wa_in] <= bus.wd_in;
                if (m_cnt[bus.wa_in] == 0) m_err <= 1'b1;
            end
            if (acc && ret && bus.issue_wa_in == bus.wa_in) begin
                m_cnt[bus.wa_in] <= m_cnt[bus.wa_in];
            end else begin
                if (acc)
                    m_cnt[bus.issue_wa_in] <= m_cnt[bus.issue_wa_in] + 1;
                if (ret && m_cnt[bus.wa_in] > 0)
                    m_cnt[bus.wa_in] <= m_cnt[bus.wa_in] - 1;
            end
        end
    end

    // Every cycle: all outputs against the model
    always @(negedge clk) begin
        chk("rd1", bus.rd1_out, exp_rd(bus.ra1_in));
        chk("rd2", bus.rd2_out, exp_rd(bus.ra2_in));
        chk("rd3", bus.rd3_out, exp_rd(bus.ra3_in));
        chk("stall", 32'(bus.stall_out), 32'(exp_stall()));
        chk("sb_err", 32'(bus.sb_err_out), 32'(m_err));
    end

    task automatic idle();
        bus.we_in = 0; bus.wa_in = 0; bus.wd_in = 0;
        bus.ra1_in = 0; bus.ra2_in = 0; bus.ra3_in = 0;
        bus.re1_in = 0; bus.re2_in = 0; bus.re3_in = 0;
        bus.issue_valid_in = 0; bus.issue_we_in = 0; bus.issue_wa_in = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [3:0] a);
        bus.issue_valid_in = 1; bus.issue_we_in = 1; bus.issue_wa_in = a;
    endtask

    task automatic wb(input logic [3:0] a, input logic [31:0] d);
        bus.we_in = 1; bus.wa_in = a; bus.wd_in = d;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        idle();
        bus.pc_in = 32'h100;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset view
        bus.ra1_in = 3; bus.ra2_in = 15; settle();
        chk("L_rst_r3", bus.rd1_out, 32'h0);
        chk("L_rst_r15", bus.rd2_out, 32'h108);
        chk("L_rst_stall", 32'(bus.stall_out), 32'h0);
        chk("L_rst_err", 32'(bus.sb_err_out), 32'h0);

        // Bypass, then stored value, then dropped r15 write
        step(); bus.ra1_in = 5; wb(5, 32'hDEADBEEF); settle();
        chk("L_bypass", bus.rd1_out, 32'hDEADBEEF);
        step(); bus.ra1_in = 5; settle();
        chk("L_stored", bus.rd1_out, 32'hDEADBEEF);
        step(); issue(5); wb(15, 32'h1234); bus.ra2_in = 15;
        step(); wb(5, 32'h0); bus.ra2_in = 15; settle();
        chk("L_r15_drop", bus.rd2_out, 32'h108);

        // RAW stall on r2 until WB retires it
        step(); issue(2);
        step(); bus.re1_in = 1; bus.ra1_in = 2; settle();
        chk("L_raw_1", 32'(bus.stall_out), 32'h1);
        step(); bus.re1_in = 1; bus.ra1_in = 2; settle();
        chk("L_raw_2", 32'(bus.stall_out), 32'h1);
        step(); bus.re1_in = 1; bus.ra1_in = 2; wb(2, 32'h55); settle();
        chk("L_raw_release", 32'(bus.stall_out), 32'h0);
        chk("L_raw_data", bus.rd1_out, 32'h55);

        // Saturation on r4
        repeat (3) begin step(); issue(4); end
        step(); issue(4); settle();
        chk("L_sat", 32'(bus.stall_out), 32'h1);
        repeat (3) begin step(); wb(4, 32'h44); end
        step(); bus.re1_in = 1; bus.ra1_in = 4; settle();
        chk("L_sat_drain", 32'(bus.stall_out), 32'h0);

        // Issue and retire of r7 in one cycle cancel out
        step(); issue(7);
        step(); issue(7); wb(7, 32'h77);
        step(); bus.re1_in = 1; bus.ra1_in = 7; settle();
        chk("L_cancel", 32'(bus.stall_out), 32'h1);
        step(); bus.re1_in = 1; bus.ra1_in = 7; wb(7, 32'h78); settle();
        chk("L_cancel_last", 32'(bus.stall_out), 32'h0);

        // Underflow and mid-stream reset
        step(); wb(9, 32'hA5);
        step(); bus.ra1_in = 9; settle();
        chk("L_uf_err", 32'(bus.sb_err_out), 32'h1);
        chk("L_uf_data", bus.rd1_out, 32'hA5);
        step(); issue(3);
        step(); bus.re1_in = 1; bus.ra1_in = 3; settle();
        chk("L_pre_rst", 32'(bus.stall_out), 32'h1);
        rst = 1; #1;
        chk("L_rst_stall_now", 32'(bus.stall_out), 32'h0);
        chk("L_rst_err_now", 32'(bus.sb_err_out), 32'h0);
        step();
        rst = 0;

        // Random traffic over a small register window
        for (int c = 0; c < 3000; c++) begin
            step();
            bus.pc_in = $urandom;
            if ($urandom_range(0, 199) == 0) rst = 1;
            else rst = 0;
            bus.we_in = ($urandom_range(0, 2) == 0);
            bus.wa_in = 4'($urandom_range(0, 5) == 0 ? 15 : $urandom_range(0, 5));
            bus.wd_in = $urandom;
            bus.ra1_in = 4'($urandom_range(0, 6) == 6 ? 15 : $urandom_range(0, 5));
            bus.ra2_in = 4'($urandom_range(0, 5));
            bus.ra3_in = 4'($urandom_range(0, 15));
            bus.re1_in = 1'($urandom_range(0, 1));
            bus.re2_in = 1'($urandom_range(0, 1));
            bus.re3_in = 1'($urandom_range(0, 1));
            bus.issue_valid_in = 1'($urandom_range(0, 1));
            bus.issue_we_in = ($urandom_range(0, 3) != 0);
            bus.issue_wa_in = 4'($urandom_range(0, 7) == 0 ? 15 : $urandom_range(0, 5));
        end
        step();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
